// File: rtl/mul_fifo_dp_if.sv
// Bundle between the FIFO next-state logic (master) and the
// state/datapath stage mul_fifo_dp (slave).
interface mul_fifo_dp_if #(
   parameter int DATA_WIDTH = 32
);
   logic [2:0]            next_state;
   logic [DATA_WIDTH-1:0] din;
   logic [2:0]            state;
   logic [3:0]            data_count;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [7:0]            err_count;

   modport master (
      output next_state, din,
      input  state, data_count, dout, full, empty,
             wr_ack, wr_err, rd_ack, rd_err, err_count
   );

   modport slave (
      input  next_state, din,
      output state, data_count, dout, full, empty,
             wr_ack, wr_err, rd_ack, rd_err, err_count
   );
endinterface

// File: rtl/mul_fifo_dp.sv
// State register and datapath of the 8-entry FIFO: storage, pointers, count, dout, strobes.
// Optional saturating error counter enabled by defining MUL_FIFO_DP_ERR_CNT_EN.
module mul_fifo_dp #(
   parameter int DATA_WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   mul_fifo_dp_if.slave     bus
);
   localparam logic [2:0] ST_INIT     = 3'b000;
   localparam logic [2:0] ST_NO_OP    = 3'b001;
   localparam logic [2:0] ST_WRITE    = 3'b010;
   localparam logic [2:0] ST_WR_ERROR = 3'b011;
   localparam logic [2:0] ST_READ     = 3'b100;
   localparam logic [2:0] ST_RD_ERROR = 3'b101;
   localparam logic [3:0] DEPTH       = 4'd8;

   logic [2:0]            state_q, state_d;
   logic [2:0]            head_q, head_d;
   logic [2:0]            tail_q, tail_d;
   logic [3:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  wr_en_d;
   logic [DATA_WIDTH-1:0] mem_q [0:7];

   // next-state action decode; defensive full/empty conversions rewrite the registered state
   always_comb begin
      state_d = bus.next_state;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      dout_d  = dout_q;
      wr_en_d = 1'b0;
      case (bus.next_state)
         ST_INIT: begin
            head_d  = 3'd0;
            tail_d  = 3'd0;
            count_d = 4'd0;
            dout_d  = '0;
         end
         ST_WRITE: begin
            if (count_q != DEPTH) begin
               wr_en_d = 1'b1;
               tail_d  = tail_q + 3'd1;
               count_d = count_q + 4'd1;
            end else begin
               state_d = ST_WR_ERROR;
            end
         end
         ST_READ: begin
            if (count_q != 4'd0) begin
               dout_d  = mem_q[head_q];
               head_d  = head_q + 3'd1;
               count_d = count_q - 4'd1;
            end else begin
               state_d = ST_RD_ERROR;
            end
         end
         ST_NO_OP, ST_WR_ERROR, ST_RD_ERROR: begin
            state_d = bus.next_state;
         end
         default: begin
            state_d = ST_NO_OP;
         end
      endcase
   end

   // control and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         head_q  <= 3'd0;
         tail_q  <= 3'd0;
         count_q <= 4'd0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   // storage array is deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem_q[tail_q] <= bus.din;
      end
   end

`ifdef MUL_FIFO_DP_ERR_CNT_EN
   logic [7:0] err_q, err_d;

   // count every edge that registers an error state, saturating at 255
   always_comb begin
      err_d = err_q;
      if (bus.next_state == ST_INIT) begin
         err_d = 8'd0;
      end else if (((state_d == ST_WR_ERROR) || (state_d == ST_RD_ERROR)) &&
                   (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end else begin
         err_d = err_q;
      end
   end

   // error counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 8'd0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err_count = err_q;
`else
   assign bus.err_count = 8'd0;
`endif

   assign bus.state      = state_q;
   assign bus.data_count = count_q;
   assign bus.dout       = dout_q;
   assign bus.full       = (count_q == DEPTH);
   assign bus.empty      = (count_q == 4'd0);
   assign bus.wr_ack     = (state_q == ST_WRITE);
   assign bus.wr_err     = (state_q == ST_WR_ERROR);
   assign bus.rd_ack     = (state_q == ST_READ);
   assign bus.rd_err     = (state_q == ST_RD_ERROR);
endmodule

// File: tb/tb_mul_fifo_dp.sv
// Scoreboard bench for mul_fifo_dp: expected read data queued at stimulus time,
// compared when the DUT registers the read.
module tb_mul_fifo_dp;
   localparam logic [2:0] INIT     = 3'b000;
   localparam logic [2:0] NO_OP    = 3'b001;
   localparam logic [2:0] WRITE    = 3'b010;
   localparam logic [2:0] WR_ERROR = 3'b011;
   localparam logic [2:0] READ     = 3'b100;
   localparam logic [2:0] RD_ERROR = 3'b101;
`ifdef MUL_FIFO_DP_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   checks_cnt;
   int   errors_cnt;

   logic [31:0] fifo_m[$];
   logic [31:0] exp_q[$];
   logic [31:0] dout_m;
   logic [2:0]  state_m;
   int          err_m;

   mul_fifo_dp_if #(.DATA_WIDTH(32)) bus ();

   mul_fifo_dp #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] strobes_of(input logic [2:0] s);
      return {s == WRITE, s == WR_ERROR, s == READ, s == RD_ERROR};
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ":state"}, {29'd0, bus.state}, {29'd0, state_m});
      chk({tag, ":count"}, {28'd0, bus.data_count}, fifo_m.size());
      chk({tag, ":dout"}, bus.dout, dout_m);
      chk({tag, ":full"}, {31'd0, bus.full}, {31'd0, fifo_m.size() == 8});
      chk({tag, ":empty"}, {31'd0, bus.empty}, {31'd0, fifo_m.size() == 0});
      chk({tag, ":strobes"},
          {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err},
          {28'd0, strobes_of(state_m)});
      chk({tag, ":err_count"}, {24'd0, bus.err_count}, err_m);
   endtask

   // drive one next_state code for one edge, update the model, then check
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] data);
      logic [2:0] es;
      es = op;
      case (op)
         INIT: begin
            fifo_m.delete();
            dout_m = 32'd0;
            err_m  = 0;
         end
         WRITE: begin
            if (fifo_m.size() < 8) fifo_m.push_back(data);
            else es = WR_ERROR;
         end
         READ: begin
            if (fifo_m.size() > 0) exp_q.push_back(fifo_m.pop_front());
            else es = RD_ERROR;
         end
         3'b110, 3'b111: es = NO_OP;
         default: es = op;
      endcase
      if (ERR_EN && (es == WR_ERROR || es == RD_ERROR) && err_m < 255) err_m++;
      state_m        = es;
      bus.next_state = op;
      bus.din        = data;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) dout_m = exp_q.pop_front();
      check_all(tag);
   endtask

   initial begin
      checks_cnt     = 0;
      errors_cnt     = 0;
      dout_m         = 32'd0;
      state_m        = INIT;
      err_m          = 0;
      reset_n        = 1'b0;
      bus.next_state = INIT;
      bus.din        = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // fill, overflow, drain, underflow
      for (int i = 0; i < 8; i++) do_op("fill", WRITE, 32'h10 + i);
      do_op("wr_error", WR_ERROR, 32'hDEAD);
      do_op("wr_full_defensive", WRITE, 32'hBEEF);
      for (int i = 0; i < 8; i++) do_op("drain", READ, 32'd0);
      do_op("rd_error", RD_ERROR, 32'd0);
      do_op("rd_empty_defensive", READ, 32'd0);
      do_op("illegal_110", 3'b110, 32'd0);
      do_op("illegal_111", 3'b111, 32'd0);
      do_op("no_op", NO_OP, 32'd0);

      // pointer wrap-around
      for (int i = 0; i < 8; i++) do_op("wrap_fill", WRITE, 32'hA0 + i);
      for (int i = 0; i < 3; i++) do_op("wrap_rd3", READ, 32'd0);
      for (int i = 0; i < 3; i++) do_op("wrap_wr3", WRITE, 32'hB0 + i);
      for (int i = 0; i < 8; i++) do_op("wrap_rd8", READ, 32'd0);

      // INIT clears count and dout
      for (int i = 0; i < 5; i++) do_op("pre_init", WRITE, 32'h50 + i);
      do_op("init", INIT, 32'd0);
      do_op("post_init_wr", WRITE, 32'hCC);
      do_op("post_init_rd", READ, 32'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) do_op("pre_reset", WRITE, 32'h60 + i);
      #2;
      reset_n = 1'b0;
      #1;
      fifo_m.delete();
      dout_m  = 32'd0;
      state_m = INIT;
      err_m   = 0;
      check_all("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      do_op("rd_after_reset", READ, 32'd0);

      // error counter saturation
      for (int i = 0; i < 300; i++) do_op("err_sat", RD_ERROR, 32'd0);
      chk("err_final", {24'd0, bus.err_count}, ERR_EN ? 32'd255 : 32'd0);
      do_op("err_init_clear", INIT, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end
endmodule

// File: doc/mul_fifo_dp.md
# mul_fifo_dp

State register and datapath stage of the 8-entry FIFO, sitting directly downstream of the FIFO next-state logic. It registers the 3-bit `next_state` code produced by that logic and performs the selected operation: storage write, storage read, pointer and count update, or clear. It produces registered data, status flags and per-operation acknowledge/error strobes. `data_count` and `state` feed back to the next-state logic.

## Interface
- `DATA_WIDTH`, 32, width of stored words and `din`/`dout`
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `next_state`  in  3  from next-state logic: INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101; 110/111 illegal
- `din`  in  DATA_WIDTH  write data, sampled on the edge that registers WRITE
- `state`  out  3  registered current state
- `data_count`  out  4  occupied entries, 0..8
- `dout`  out  DATA_WIDTH  registered read data
- `full`  out  1  `data_count == 8`
- `empty`  out  1  `data_count == 0`
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err`  out  1 each  state decodes: WRITE, WR_ERROR, READ, RD_ERROR
- `err_count`  out  8  saturating error counter (see Configuration)

## Operation
- Storage: 8 x DATA_WIDTH register array; `head`[2:0] is the read pointer and `tail`[2:0] is the write pointer; both wrap modulo 8 (7 -> 0).
- Every rising edge: `state <= next_state`; the action below is taken on the same edge, decoded from `next_state`:
  - INIT: head, tail, data_count <- 0; dout <- 0; array contents untouched.
  - WRITE: if data_count < 8, mem[tail] <= din, tail++, data_count++. If data_count == 8 (defensive), no write and `state <= WR_ERROR`.
  - READ: if data_count > 0, dout <= mem[head], head++, data_count--. If data_count == 0 (defensive), no read and `state <= RD_ERROR`.
  - NO_OP, WR_ERROR, RD_ERROR: pointers, count, array and dout hold.
  - 110/111: treated as NO_OP; `state <= NO_OP`.
- Simultaneous read and write requests never arrive here, because the upstream logic maps them to NO_OP. This block performs no concurrent read/write.
- `full`, `empty` and the strobes are combinational decodes of registered `data_count`/`state`, so they are glitch-free relative to `clk`.

## Timing
- Reset (async assert, any time): state=INIT, head=tail=0, data_count=0, dout=0, err_count=0; therefore empty=1, full=0, all strobes 0. Array contents are not reset.
- Reset deassertion is synchronised externally. The first active edge after release applies `next_state`.
- Latency: `din` captured on edge N; readable by a READ registered on edge N+1 or later.
- READ on edge N: `dout` valid after edge N and held until the next successful READ or INIT.
- Strobes are high for exactly the cycles in which `state` holds the matching code. Back-to-back operations give continuous strobes.
- `data_count` after edge N already reflects the edge-N action. The upstream full/empty error decision uses this value combinationally in cycle N.
- Reset mid-stream discards all buffered words (count 0). Data is not recoverable.

## Configuration
- `MUL_FIFO_DP_ERR_CNT_EN` defined:
  - `err_count` increments by 1 on every edge that registers WR_ERROR or RD_ERROR, including defensive conversions.
  - Saturates at 255.
  - Cleared by reset and by INIT.
- Not defined: `err_count` is constant 0 and no counter flops are built.

## Test plan
- Reset, then 8 WRITEs with din=0x10..0x17 -> data_count 1..8, wr_ack each cycle, full=1 after 8th; then WR_ERROR -> wr_err=1, count stays 8, no write.
- From full, 8 READs -> dout=0x10..0x17 in order, rd_ack each cycle, empty=1 after last; then RD_ERROR -> rd_err=1, dout holds 0x17.
- Wrap-around test:
  - Stimulus: write 0xA0..0xA7, read 3, write 0xB0..0xB2 (tail wraps to 3), then read 8.
  - Required response: dout = 0xA3..0xA7, then 0xB0..0xB2; count ends at 0.
- Write 5 words, then INIT -> count=0, dout=0, empty=1; next WRITE 0xCC then READ -> dout=0xCC.
- Reset mid-operation:
  - Stimulus: assert reset_n=0 between edges after 4 writes.
  - Required response: outputs go to reset values immediately, without waiting for `clk`; after release, READ request converts to RD_ERROR.
- With `MUL_FIFO_DP_ERR_CNT_EN`, 300 consecutive RD_ERRORs on empty -> err_count=255. Without the macro, err_count=0 throughout.
